// File: rtl/rv_pkg.sv
// Shared core definitions: default data width, register index type, x0 index.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;

  typedef logic [$clog2(NREG_DEFAULT)-1:0] reg_idx_t;

  // Architectural zero register; reads 0, never written, never busy.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/rv_regfile_sb_if.sv
// Bundle between ID/WB (master) and the register file (slave).
// Latency: n/a (wires only).
// Backpressure: issue_ready flows slave -> master; everything else is fire-and-forget.
// Ports: rs_addr/rs_data/rs_busy read ports, issue_* pending-write issue,
//        wb_* write-back, flush, pending_any status.
interface rv_regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREG);

  logic [NREAD*AW-1:0]   rs_addr;
  logic [NREAD*XLEN-1:0] rs_data;
  logic [NREAD-1:0]      rs_busy;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic                  issue_ready;
  logic                  wb_valid;
  logic [AW-1:0]         wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  flush;
  logic                  pending_any;

  modport master (
    output rs_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, flush,
    input  rs_data, rs_busy, issue_ready, pending_any
  );

  modport slave (
    input  rs_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_data, flush,
    output rs_data, rs_busy, issue_ready, pending_any
  );
endinterface

// File: rtl/rv_regfile_sb_pend_counter.sv
// Saturating up/down counter of outstanding writes for one register.
// Latency: 1 cycle from inc/dec/clr to count; zero/full/multi are combinational from the count.
// Backpressure: none; caller gates inc with full. Simultaneous inc+dec holds, clr wins.
// Ports: clk, rst_n; inc, dec, clr in; zero (cnt==0), full (cnt==max), multi (cnt>1) out.
module rv_pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic full,
  output logic multi
);
  logic [PEND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      // A write-back with nothing outstanding is legal after a flush.
      if (!zero) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero  = (cnt_q == '0);
  assign full  = (cnt_q == '1);
  assign multi = !zero && (cnt_q != PEND_W'(1));
endmodule

// File: rtl/rv_regfile_sb.sv
// Integer register file with NREAD combinational reads, one write-back port and a
// per-register pending-write scoreboard. Optional write-to-read bypass: RF_BYPASS_EN.
// Latency: reads 0 cycles; write and issue->busy 1 cycle (wb->not-busy 0 cycles with bypass).
// Backpressure: issue_ready drops only when the destination counter is full and no same-cycle wb retires one.
// Ports: clk, rst_n plain; bus (slave modport) carries read, issue, write-back, flush, status.
module rv_regfile_sb
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREG   = NREG_DEFAULT,
  parameter int NREAD  = 2,
  parameter int PEND_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  rv_regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] cnt_zero, cnt_full, cnt_multi;
  logic            issue_acc;
  logic            ready;

  // ---------------- register array ----------------
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_valid && bus.wb_rd != ZERO && int'(bus.wb_rd) < NREG)
      regs_d[bus.wb_rd] = bus.wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------- scoreboard ----------------
  always_comb begin
    ready = 1'b1;
    if (bus.issue_rd != ZERO && int'(bus.issue_rd) < NREG) begin
      if (cnt_full[bus.issue_rd] && !(bus.wb_valid && bus.wb_rd == bus.issue_rd))
        ready = 1'b0;
    end
  end

  assign bus.issue_ready = ready;
  assign issue_acc       = bus.issue_valid && ready && !bus.flush;

  // x0 has no counter: permanently idle.
  assign cnt_zero[0]  = 1'b1;
  assign cnt_full[0]  = 1'b0;
  assign cnt_multi[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    rv_pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (issue_acc && bus.issue_rd == AW'(r)),
      .dec   (bus.wb_valid && bus.wb_rd == AW'(r)),
      .clr   (bus.flush),
      .zero  (cnt_zero[r]),
      .full  (cnt_full[r]),
      .multi (cnt_multi[r])
    );
  end

  assign bus.pending_any = !(&cnt_zero);

  // ---------------- read ports ----------------
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic            byp;
    logic [XLEN-1:0] rd_dat;
    logic            rd_busy;

    assign a = bus.rs_addr[k*AW +: AW];

`ifdef RF_BYPASS_EN
    assign byp = bus.wb_valid && bus.wb_rd == a;
`else
    assign byp = 1'b0;
`endif

    // A bypassed wb retires one outstanding write this cycle, so the port
    // is still busy only if more than one was pending.
    always_comb begin
      rd_dat  = '0;
      rd_busy = 1'b0;
      if (a != ZERO && int'(a) < NREG) begin
        rd_dat  = byp ? bus.wb_data  : regs_q[a];
        rd_busy = byp ? cnt_multi[a] : !cnt_zero[a];
      end
    end

    assign bus.rs_data[k*XLEN +: XLEN] = rd_dat;
    assign bus.rs_busy[k]              = rd_busy;
  end
endmodule

// File: tb/tb_rv_regfile_sb.sv
// Directed bench for rv_regfile_sb with hand-computed expectations.
// Latency: inputs driven 1 time unit after posedge, outputs checked 2 units later.
// Backpressure: issue_ready checked directly against the expected value.
module tb_rv_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NREAD = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rv_regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) rf_if ();

  rv_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .PEND_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_if.issue_valid = 1'b0;
    rf_if.issue_rd    = '0;
    rf_if.wb_valid    = 1'b0;
    rf_if.wb_rd       = '0;
    rf_if.wb_data     = '0;
    rf_if.flush       = 1'b0;
  endtask

  task automatic rd_addr(input int p1, input int p0);
    rf_if.rs_addr = {5'(p1), 5'(p0)};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rd_addr(5, 5);
    #2;
    chk("rst_data_in_reset", 64'(rf_if.rs_data), 64'h0);
    #10;
    rst_n = 1'b1;
    tick();

    // Reset state, read x5 on both ports.
    #2;
    chk("rst_data",    64'(rf_if.rs_data), 64'h0);
    chk("rst_busy",    64'(rf_if.rs_busy), 64'h0);
    chk("rst_ready",   64'(rf_if.issue_ready), 64'h1);
    chk("rst_pending", 64'(rf_if.pending_any), 64'h0);

    // Issue x5 in cycle 0, wb in cycle 3.
    tick();
    rf_if.issue_valid = 1'b1; rf_if.issue_rd = 5'd5;
    #2;
    chk("iss5_ready", 64'(rf_if.issue_ready), 64'h1);
    chk("iss5_busy_c0", 64'(rf_if.rs_busy), 64'h0);
    tick();
    idle();
    #2;
    chk("iss5_busy_c1", 64'(rf_if.rs_busy), 64'h3);
    chk("iss5_pend_c1", 64'(rf_if.pending_any), 64'h1);
    tick();
    #2;
    chk("iss5_busy_c2", 64'(rf_if.rs_busy), 64'h3);
    tick();
    rf_if.wb_valid = 1'b1; rf_if.wb_rd = 5'd5; rf_if.wb_data = 32'hDEADBEEF;
    #2;
`ifdef RF_BYPASS_EN
    chk("wb5_busy_c3", 64'(rf_if.rs_busy), 64'h0);
    chk("wb5_data_c3", 64'(rf_if.rs_data), 64'hDEADBEEF_DEADBEEF);
`else
    chk("wb5_busy_c3", 64'(rf_if.rs_busy), 64'h3);
    chk("wb5_data_c3", 64'(rf_if.rs_data), 64'h0);
`endif
    tick();
    idle();
    #2;
    chk("wb5_busy_c4", 64'(rf_if.rs_busy), 64'h0);
    chk("wb5_data_c4", 64'(rf_if.rs_data), 64'hDEADBEEF_DEADBEEF);
    chk("wb5_pend_c4", 64'(rf_if.pending_any), 64'h0);

    // Saturate x7 (PEND_W=2 -> max 3 outstanding).
    rf_if.issue_valid = 1'b1; rf_if.issue_rd = 5'd7;
    tick();
    tick();
    tick();
    #2;
    chk("x7_full_ready", 64'(rf_if.issue_ready), 64'h0);
    rf_if.wb_valid = 1'b1; rf_if.wb_rd = 5'd7; rf_if.wb_data = 32'h77;
    #1;
    chk("x7_full_wb_ready", 64'(rf_if.issue_ready), 64'h1);
    tick();
    idle();
    rf_if.issue_rd = 5'd7;
    rd_addr(0, 7);
    #2;
    chk("x7_still_full", 64'(rf_if.issue_ready), 64'h0);
    chk("x7_busy", 64'(rf_if.rs_busy), 64'h1);
    chk("x7_data", 64'(rf_if.rs_data[31:0]), 64'h77);

    // Flush with outstanding x3/x4/x7 and a same-cycle wb to x3.
    rf_if.issue_valid = 1'b1; rf_if.issue_rd = 5'd3;
    tick();
    rf_if.issue_rd = 5'd4;
    tick();
    rf_if.flush = 1'b1;
    rf_if.wb_valid = 1'b1; rf_if.wb_rd = 5'd3; rf_if.wb_data = 32'h11;
    tick();
    idle();
    rd_addr(4, 3);
    #2;
    chk("flush_busy", 64'(rf_if.rs_busy), 64'h0);
    chk("flush_pend", 64'(rf_if.pending_any), 64'h0);
    chk("flush_x3",   64'(rf_if.rs_data[31:0]), 64'h11);
    rf_if.issue_rd = 5'd7;
    #1;
    chk("flush_x7_ready", 64'(rf_if.issue_ready), 64'h1);
    rf_if.wb_valid = 1'b1; rf_if.wb_rd = 5'd4; rf_if.wb_data = 32'hAB;
    tick();
    idle();
    #2;
    chk("late_wb_x4",   64'(rf_if.rs_data[63:32]), 64'hAB);
    chk("late_wb_busy", 64'(rf_if.rs_busy), 64'h0);
    chk("late_wb_pend", 64'(rf_if.pending_any), 64'h0);

    // x0: wb and issue are no-ops.
    rf_if.wb_valid = 1'b1; rf_if.wb_rd = 5'd0; rf_if.wb_data = 32'h1234;
    rf_if.issue_valid = 1'b1; rf_if.issue_rd = 5'd0;
    rd_addr(0, 0);
    #2;
    chk("x0_ready", 64'(rf_if.issue_ready), 64'h1);
    tick();
    idle();
    #2;
    chk("x0_data", 64'(rf_if.rs_data), 64'h0);
    chk("x0_busy", 64'(rf_if.rs_busy), 64'h0);
    chk("x0_pend", 64'(rf_if.pending_any), 64'h0);

    // x9 = 0x55 with two outstanding writes, then async reset mid-cycle.
    rf_if.wb_valid = 1'b1; rf_if.wb_rd = 5'd9; rf_if.wb_data = 32'h55;
    tick();
    idle();
    rf_if.issue_valid = 1'b1; rf_if.issue_rd = 5'd9;
    tick();
    tick();
    idle();
    rd_addr(9, 9);
    #2;
    chk("x9_busy_pre", 64'(rf_if.rs_busy), 64'h3);
    chk("x9_data_pre", 64'(rf_if.rs_data), 64'h00000055_00000055);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(rf_if.rs_busy), 64'h0);
    chk("arst_data", 64'(rf_if.rs_data), 64'h0);
    chk("arst_pend", 64'(rf_if.pending_any), 64'h0);
    chk("arst_ready", 64'(rf_if.issue_ready), 64'h1);
    #10;
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_regfile_sb.md
# rv_regfile_sb

Parametrised integer register file with a pending-write scoreboard for the pipelined RISC-V core. It provides NREAD combinational read ports, one synchronous write-back port, and an optional write-to-read bypass. It also tracks outstanding writes per architectural register so that ID can stall on RAW hazards instead of relying only on EXE/MEM forwarding. It sits between ID (issue and reads) and WB (write-back), and replaces the bare register array plus ad-hoc forwarding of the previous core.

## Interface
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; 16 for RV32E. Derived AW = $clog2(NREG).
- NREAD, 2, number of read ports; 1..4.
- PEND_W, 2, width of each pending counter. Maximum outstanding writes per register is 2^PEND_W-1.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rs_addr  in  NREAD*AW  read addresses; port k is in bits [k*AW +: AW].
- rs_data  out  NREAD*XLEN  read data per port.
- rs_busy  out  NREAD  port k's register has a write outstanding.
- issue_valid  in  1  ID issues an instruction that will write issue_rd.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_ready  out  1  the issue can be accepted this cycle.
- wb_valid  in  1  WB writes wb_data to wb_rd.
- wb_rd  in  AW  write-back destination.
- wb_data  in  XLEN  write-back data.
- flush  in  1  pipeline kill; all pending counters are cleared.
- pending_any  out  1  at least one counter is non-zero.

## Operation
- Register array NREG x XLEN. Register x0 reads 0, ignores writes, is never busy, and issue to x0 is always ready and a no-op.
- Write: when wb_valid and wb_rd != 0, reg[wb_rd] <= wb_data at the clock edge.
- Pending counter cnt[r], one per register r from 1 to NREG-1:
  - issue accepted only: +1.
  - wb only: -1, saturating at 0; a wb with cnt 0 is legal after a flush and the write is still performed.
  - issue and wb to the same r in the same cycle: unchanged.
  - flush: every cnt <= 0. A simultaneous issue is dropped and a simultaneous wb write is still performed. Flush has priority over issue and wb counting.
- Issue is accepted when issue_valid && issue_ready && !flush.
- issue_ready = 0 only when cnt[issue_rd] == 2^PEND_W-1 and there is no same-cycle wb to issue_rd.
- Reads are combinational from the array, or from the bypass (see Configuration).
- rs_busy[k] = (cnt[a] != 0) for a = rs_addr port k, with the bypass adjustment. It is always 0 for a == 0.
- pending_any = OR of all cnt != 0.
- Out-of-range addresses (a >= NREG, possible when NREG is not a power of two) read 0, are never busy, and writes to them are ignored.

## Timing
- Read latency: 0 cycles, combinational on rs_addr.
- Write latency: 1 cycle. Without bypass, data written in cycle n is visible to reads in cycle n+1.
- Issue to rs_busy high: next cycle.
- WB to rs_busy low: next cycle without bypass, same cycle with bypass.
- Reset (async assert, sync deassert expected upstream):
  - all registers 0 and all cnt 0;
  - rs_data 0, rs_busy 0, pending_any 0, issue_ready 1.
- Reset asserted mid-operation discards all pending state immediately.
- All outputs are combinational from the state and current inputs; there are no registered outputs.

## Configuration
- RF_BYPASS_EN defined:
  - if wb_valid && wb_rd == a && a != 0, then rs_data for that port = wb_data;
  - rs_busy for that port = (cnt[a] > 1), i.e. the wb retires one outstanding write in the same cycle.
- RF_BYPASS_EN undefined:
  - rs_data comes from the array only;
  - rs_busy = (cnt[a] != 0);
  - a same-cycle wb is visible next cycle.

## Structure
- Shared package rv_pkg holds:
  - the XLEN default;
  - the reg_idx_t typedef;
  - the ZERO_REG constant (0).
- Sub-module rv_pend_counter: one PEND_W-bit saturating up/down counter with inputs inc, dec and clr, and outputs zero and full. It is instantiated NREG-1 times in a generate loop.
- The read ports are a generate loop over NREAD.

## Test plan
- Reset, then read x5 on both ports -> rs_data 0, rs_busy 0, issue_ready 1, pending_any 0.
- Issue rd=5 in cycle 0, wb x5=0xDEADBEEF in cycle 3 -> rs_busy high in cycles 1–3, data 0xDEADBEEF from cycle 4. With RF_BYPASS_EN: busy low and data valid already in cycle 3.
- PEND_W=2, issue rd=7 three times -> issue_ready 0 for rd=7. Simultaneous issue rd=7 and wb x7 -> accepted, cnt stays 3.
- Issue rd=3 and rd=4, then flush together with wb x3=0x11 -> all busy 0, pending_any 0, x3 reads 0x11. A later wb to x4 is written and cnt stays 0.
- wb x0=0x1234 and issue rd=0 -> x0 reads 0, rs_busy 0, pending_any 0.
- Assert rst_n low asynchronously mid-cycle with cnt[9]=2 and x9=0x55 -> immediately rs_busy 0 and rs_data 0 for x9.
